// File: rtl/sram_ctrl.sv
// Word-to-halfword bridge from the MEM stage to a 16-bit asynchronous SRAM.
// Optional address range/alignment checking is enabled with SRAM_CTRL_ADDR_CHECK_EN.
module sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned IdxW = SRAM_AW - 1;

  typedef enum logic [2:0] {StIdle, StLo, StHi, StWait, StDone} state_e;

  state_e          state;
  logic [IdxW-1:0] idx_q;
  logic [15:0]     hi_data_q;
  logic            op_wr_q;
  logic [3:0]      wait_cnt;

  logic            req;
  logic            req_illegal;
  logic [IdxW-1:0] req_idx;

  assign req     = rd_en | wr_en;
  assign req_idx = IdxW'((address - BASE_ADDR) >> 2);
  assign ready   = (state == StDone) | ((state == StIdle) & ~rd_en & ~wr_en);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic [31:0] offset;
  assign offset      = address - BASE_ADDR;
  assign req_illegal = (address < BASE_ADDR) | (address[1:0] != 2'b00) |
                       (|offset[31:SRAM_AW+1]);
`else
  assign req_illegal = 1'b0;
  assign addr_err    = 1'b0;
`endif

  // Strobes are loaded on the transition into the state that uses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      wait_cnt    <= '0;
      idx_q       <= '0;
      hi_data_q   <= '0;
      op_wr_q     <= 1'b0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (req) begin
            idx_q     <= req_idx;
            hi_data_q <= write_data[31:16];
            op_wr_q   <= wr_en;
            if (req_illegal) begin
              state <= StDone;
              if (!wr_en) read_data <= '0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
              addr_err <= 1'b1;
`endif
            end else begin
              state       <= StLo;
              sram_addr   <= {req_idx, 1'b0};
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= wr_en;
              sram_we_n   <= ~wr_en;
            end
          end
        end
        StLo: begin
          if (!op_wr_q) read_data[15:0] <= sram_dq_in;
          sram_addr   <= {idx_q, 1'b1};
          sram_dq_out <= hi_data_q;
          sram_dq_oe  <= op_wr_q;
          sram_we_n   <= ~op_wr_q;
          state       <= StHi;
        end
        StHi: begin
          if (!op_wr_q) read_data[31:16] <= sram_dq_in;
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          wait_cnt   <= 4'(WAIT_CYCLES - 1);
          state      <= StWait;
        end
        StWait: begin
          if (wait_cnt == 4'd0) state <= StDone;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        StDone: begin
          state <= StIdle;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
          addr_err <= 1'b0;
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
